// File: rtl/div_seq.sv
// div_seq: multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation at a time. It holds the pipeline while busy and returns the
// result with a one-cycle register write strobe.
// Build option: define DIV_SEQ_EARLY_OUT_EN to resolve three cases at capture
// and go straight to DONE: divide-by-zero, signed overflow and
// |divisor| > |dividend|.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              hold_req_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] result_o,
    output logic              reg_we_o,
    output logic [4:0]        reg_waddr_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] a_reg;        // raw dividend, needed for the divide-by-zero remainder
    logic [DATA_W-1:0] dmag_reg;     // |divisor|
    logic [DATA_W-1:0] quo_reg;      // holds |dividend| at first and becomes the quotient bit by bit
    logic [DATA_W-1:0] rem_reg;      // partial remainder, always < dmag_reg between steps
    logic [DATA_W-1:0] result_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              is_rem_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              div0_reg;
    logic              ovf_reg;
    logic [4:0]        waddr_reg;

    logic              in_signed_next;
    logic              a_neg_next;
    logic              b_neg_next;
    logic              div0_next;
    logic              ovf_next;
    logic [DATA_W-1:0] a_mag_next;
    logic [DATA_W-1:0] b_mag_next;

    logic [DATA_W:0]   shift_next;
    logic [DATA_W:0]   diff_next;
    logic              fits_next;

    logic [DATA_W-1:0] quo_fix_next;
    logic [DATA_W-1:0] rem_fix_next;
    logic [DATA_W-1:0] done_result_next;

    // Decode the incoming operands: their signs, their magnitudes and the special cases
    always_comb begin
        in_signed_next = op_i[2] & ~op_i[0];
        a_neg_next     = in_signed_next & dividend_i[DATA_W-1];
        b_neg_next     = in_signed_next & divisor_i[DATA_W-1];
        a_mag_next     = a_neg_next ? (~dividend_i + ONE) : dividend_i;
        b_mag_next     = b_neg_next ? (~divisor_i + ONE) : divisor_i;
        div0_next      = (divisor_i == '0);
        ovf_next       = in_signed_next & (dividend_i == MIN_NEG) & (divisor_i == '1);
    end

`ifdef DIV_SEQ_EARLY_OUT_EN
    logic early_next;
    assign early_next = div0_next | ovf_next | (b_mag_next > a_mag_next);
`endif

    // One restoring step.
    // Because rem < |divisor|, the shifted value is < 2*|divisor|. The top bit
    // of the difference therefore acts as the borrow, and its inverse is the
    // "fits" decision.
    always_comb begin
        shift_next = {rem_reg, quo_reg[DATA_W-1]};
        diff_next  = shift_next - {1'b0, dmag_reg};
        fits_next  = ~diff_next[DATA_W];
    end

    // Final sign fix-up, with special-case overrides, to form the architectural result
    always_comb begin
        quo_fix_next = neg_q_reg ? (~quo_reg + ONE) : quo_reg;
        rem_fix_next = neg_r_reg ? (~rem_reg + ONE) : rem_reg;
        if (div0_reg) begin
            quo_fix_next = '1;
            rem_fix_next = a_reg;
        end else if (ovf_reg) begin
            quo_fix_next = MIN_NEG;
            rem_fix_next = '0;
        end
        done_result_next = is_rem_reg ? rem_fix_next : quo_fix_next;
    end

    // Control FSM and datapath: capture in IDLE, iterate in CALC, publish in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            dmag_reg   <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            is_rem_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            waddr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        a_reg      <= dividend_i;
                        dmag_reg   <= b_mag_next;
                        quo_reg    <= a_mag_next;
                        rem_reg    <= '0;
                        cnt_reg    <= CNT_W'(DATA_W);
                        is_rem_reg <= op_i[1];
                        neg_q_reg  <= a_neg_next ^ b_neg_next;
                        neg_r_reg  <= a_neg_next;
                        div0_reg   <= div0_next;
                        ovf_reg    <= ovf_next;
                        waddr_reg  <= reg_waddr_i;
`ifdef DIV_SEQ_EARLY_OUT_EN
                        if (early_next) begin
                            // Quotient 0 and remainder |a| give the right answer
                            // for |b| > |a|; the other two cases are overridden in DONE.
                            quo_reg   <= '0;
                            rem_reg   <= a_mag_next;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
`else
                        state_reg  <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        state_reg <= IDLE;
                    end else begin
                        quo_reg <= {quo_reg[DATA_W-2:0], fits_next};
                        rem_reg <= fits_next ? diff_next[DATA_W-1:0] : shift_next[DATA_W-1:0];
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    if (!abort_i) begin
                        result_reg <= done_result_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ready_o depends on abort_i combinationally, so an abort during DONE
    // suppresses the write strobe in that same cycle.
    assign busy_o      = (state_reg != IDLE);
    assign hold_req_o  = busy_o | (start_i & (state_reg == IDLE));
    assign ready_o     = (state_reg == DONE) & ~abort_i;
    assign reg_we_o    = ready_o;
    assign result_o    = ready_o ? done_result_next : result_reg;
    assign reg_waddr_o = waddr_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq. Every expected value is hand-computed.
// Cycle 0 is the cycle in which start_i is sampled. The default build expects
// ready_o in cycle 33. With DIV_SEQ_EARLY_OUT_EN, the early-out cases expect it
// in cycle 1.
module tb_div_seq;
    localparam int FULL_LAT = 33;
`ifdef DIV_SEQ_EARLY_OUT_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 33;
`endif
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        abort_i;
    logic        busy_o;
    logic        hold_req_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last_res = 32'h0;

    div_seq #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .hold_req_o  (hold_req_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch one op from a negedge in IDLE, then check latency, result, strobe and rd.
    // Returns at the negedge of the cycle after ready, when the DUT is IDLE again.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
        #1;
        n_cmp++;
        if (hold_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s hold_req_at_start: got %b want 1", name, hold_req_o);
        end
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; op_i = 3'b000; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h0; reg_waddr_i = 5'd0;
        for (int c = 1; c <= 40; c++) begin
            if (ready_o === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d (0 = no ready_o)", name, lat, exp_lat);
        end
        if (lat != 0) begin
            n_cmp++;
            if (result_o !== exp_res) begin
                n_fail++;
                $display("FAIL %s result: got %h want %h", name, result_o, exp_res);
            end
            n_cmp++;
            if (reg_we_o !== 1'b1 || reg_waddr_o !== rd) begin
                n_fail++;
                $display("FAIL %s reg_write: got we=%b rd=%0d want we=1 rd=%0d", name, reg_we_o, reg_waddr_o, rd);
            end
            @(negedge clk);
            n_cmp++;
            if (ready_o !== 1'b0 || reg_we_o !== 1'b0 || result_o !== exp_res || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after_ready: got ready=%b we=%b busy=%b res=%h want 0/0/0/%h",
                         name, ready_o, reg_we_o, busy_o, result_o, exp_res);
            end
        end
        last_res = exp_res;
        $display("op %-18s a=%h b=%h rd=%0d -> %h latency %0d", name, a, b, rd, result_o, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; op_i = 3'b000; dividend_i = 32'h0; divisor_i = 32'h0;
        reg_waddr_i = 5'd0; abort_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || reg_we_o !== 1'b0 || hold_req_o !== 1'b0 ||
            result_o !== 32'h0 || reg_waddr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b rdy=%b we=%b hold=%b res=%h rd=%0d want all 0",
                     busy_o, ready_o, reg_we_o, hold_req_o, result_o, reg_waddr_o);
        end
        $display("reset: busy=%b ready=%b result=%h", busy_o, ready_o, result_o);
    endtask

    task automatic test_basic();
        run_op("div_100_7",  OP_DIV,  32'd100, 32'd7, 5'd5, 32'd14, FULL_LAT);
        run_op("rem_100_7",  OP_REM,  32'd100, 32'd7, 5'd6, 32'd2,  FULL_LAT);
        run_op("divu_7_7",   OP_DIVU, 32'd7,   32'd7, 5'd7, 32'd1,  FULL_LAT);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'hFFFF_FFFF, FULL_LAT);
    endtask

    task automatic test_signed();
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, FULL_LAT);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, FULL_LAT);
        run_op("divu_fff9_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'h7FFF_FFFC, FULL_LAT);
        run_op("div_100_m7", OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd13, 32'hFFFF_FFF2, FULL_LAT);
        run_op("rem_100_m7", OP_REM,  32'd100, 32'hFFFF_FFF9, 5'd14, 32'd2, FULL_LAT);
    endtask

    task automatic test_special();
        run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, FAST_LAT);
        run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 5'd16, 32'd5, FAST_LAT);
        run_op("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 5'd17, 32'hFFFF_FFFF, FAST_LAT);
        run_op("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFB, FAST_LAT);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, FAST_LAT);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0, FAST_LAT);
    endtask

    task automatic test_early_out();
        run_op("divu_3_10",  OP_DIVU, 32'd3, 32'd10, 5'd21, 32'd0, FAST_LAT);
        run_op("remu_3_10",  OP_REMU, 32'd3, 32'd10, 5'd22, 32'd3, FAST_LAT);
        run_op("div_m3_10",  OP_DIV,  32'hFFFF_FFFD, 32'd10, 5'd23, 32'd0, FAST_LAT);
        run_op("rem_m3_10",  OP_REM,  32'hFFFF_FFFD, 32'd10, 5'd24, 32'hFFFF_FFFD, FAST_LAT);
    endtask

    task automatic test_abort_calc();
        int seen;
        start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd25;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        abort_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_calc_cycle: got ready=%b busy=%b want 0/1", ready_o, busy_o);
        end
        @(posedge clk);
        @(negedge clk);
        abort_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0 || result_o !== last_res) begin
            n_fail++;
            $display("FAIL abort_calc_after: got busy=%b res=%h want 0/%h", busy_o, result_o, last_res);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_calc_no_ready: got %0d ready cycles want 0", seen);
        end
        $display("abort in CALC cycle 10: busy=%b stray_ready=%0d", busy_o, seen);
        run_op("divu_3_1_after_abort", OP_DIVU, 32'd3, 32'd1, 5'd26, 32'd3, FULL_LAT);
    endtask

    task automatic test_abort_done();
        int seen;
        start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd27;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (31) @(negedge clk);
        @(posedge clk);
        #1;
        abort_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b0 || reg_we_o !== 1'b0 || busy_o !== 1'b1 || result_o !== last_res) begin
            n_fail++;
            $display("FAIL abort_done_cycle: got ready=%b we=%b busy=%b res=%h want 0/0/1/%h",
                     ready_o, reg_we_o, busy_o, result_o, last_res);
        end
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0 || result_o !== last_res) begin
            n_fail++;
            $display("FAIL abort_done_after: got busy=%b res=%h want 0/%h", busy_o, result_o, last_res);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_done_no_ready: got %0d ready cycles want 0", seen);
        end
        $display("abort in DONE: busy=%b stray_ready=%0d result=%h", busy_o, seen, result_o);
    endtask

    task automatic test_start_abort_idle();
        int seen;
        start_i = 1'b1; abort_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3; reg_waddr_i = 5'd28;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle_busy: got %b want 0", busy_o);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0 || reg_waddr_o === 5'd28) begin
            n_fail++;
            $display("FAIL start_abort_idle_capture: got ready_cycles=%0d rd=%0d want 0 and rd!=28", seen, reg_waddr_o);
        end
        $display("start+abort in IDLE: busy=%b stray_ready=%0d", busy_o, seen);
    endtask

    task automatic test_busy_ignore();
        int lat;
        lat = 0;
        start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd20; divisor_i = 32'd3; reg_waddr_i = 5'd9;
        @(posedge clk);
        @(negedge clk);
        op_i = OP_DIV; dividend_i = 32'd1000; divisor_i = 32'd1; reg_waddr_i = 5'd1;
        n_cmp++;
        if (busy_o !== 1'b1 || hold_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore_busy: got busy=%b hold=%b want 1/1", busy_o, hold_req_o);
        end
        for (int c = 1; c <= 40; c++) begin
            if (ready_o === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (lat != FULL_LAT || result_o !== 32'd6 || reg_waddr_o !== 5'd9) begin
            n_fail++;
            $display("FAIL busy_ignore_result: got lat=%0d res=%h rd=%0d want %0d/00000006/9",
                     lat, result_o, reg_waddr_o, FULL_LAT);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore_done_start: got busy=%b want 0", busy_o);
        end
        @(negedge clk);
        last_res = 32'd6;
        $display("start held while busy: result=%h latency %0d", 32'd6, lat);
    endtask

    task automatic test_reset_mid_op();
        int seen;
        start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd3;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || reg_we_o !== 1'b0 || result_o !== 32'h0 || reg_waddr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b rdy=%b we=%b res=%h rd=%0d want all 0",
                     busy_o, ready_o, reg_we_o, result_o, reg_waddr_o);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_op_no_ready: got %0d ready cycles want 0", seen);
        end
        last_res = 32'h0;
        $display("reset at cycle 5: busy=%b stray_ready=%0d", busy_o, seen);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_divu_1000_10", OP_DIVU, 32'd1000, 32'd10, 5'd29, 32'd100, FULL_LAT);
        run_op("b2b_remu_1000_7",  OP_REMU, 32'd1000, 32'd7,  5'd30, 32'd6,   FULL_LAT);
        run_op("b2b_divu_3_10",    OP_DIVU, 32'd3,    32'd10, 5'd31, 32'd0,   FAST_LAT);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_basic();
        test_signed();
        test_special();
        test_early_out();
        test_abort_calc();
        test_abort_done();
        test_start_abort_idle();
        test_busy_ignore();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
